// File: rtl/uart_pkg.sv
// Shared UART definitions: default FIFO geometry and the status word seen by the APB block.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: registered write port, combinational read port addressed by the read pointer.
// Contents are deliberately not reset.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock parametrised FIFO for the UART TX/RX paths with occupancy count,
// almost-full/empty thresholds, sticky overflow/underflow flags and synchronous flush.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_C = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LVL);

  logic [CW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] head;
  logic              wr_acc, rd_acc;
  fifo_status_t      status;

  // The extra MSB distinguishes full from empty when the address bits match.
  always_comb begin
    status              = '0;
    status.empty        = (wr_ptr == rd_ptr);
    status.full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    status.almost_full  = (count >= AF_C);
    status.almost_empty = (count <= AE_C);
    status.overflow     = overflow;
    status.underflow    = underflow;
  end

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

  // Acceptance uses pre-edge full/empty, so no write-through or pass-through.
  assign wr_acc = wr_en && !status.full  && !flush;
  assign rd_acc = rd_en && !status.empty && !flush;

  uart_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + CW'(1);
        rd_data <= head;
      end
      if (wr_en && status.full)  overflow  <= 1'b1;
      if (rd_en && status.empty) underflow <= 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed bench for uart_sync_fifo (DEPTH 16): vector table plus hand sequences for fill,
// overflow, pointer wrap, flush and asynchronous reset.
module tb_uart_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_rd = 8'h00;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uart_sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       fl;
    int         cnt;
    logic       ovf;
    logic       udf;
    logic       rv;
    logic [7:0] rdat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_stat(input string tag, input int cnt, input logic ovf, input logic udf);
    chk({tag, ".count"},        32'(count),        32'(cnt));
    chk({tag, ".empty"},        32'(empty),        32'(cnt == 0));
    chk({tag, ".full"},         32'(full),         32'(cnt == 16));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(cnt >= 14));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= 2));
    chk({tag, ".overflow"},     32'(overflow),     32'(ovf));
    chk({tag, ".underflow"},    32'(underflow),    32'(udf));
  endtask

  task automatic chk_rd(input string tag, input logic rv, input logic [7:0] exp);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(rv));
    chk({tag, ".rd_data"},  32'(rd_data),  32'(exp));
    last_rd = exp;
  endtask

  // Drive one cycle's request, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f);
    wr_en = w; wr_data = d; rd_en = r; flush = f;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_stat(tag, 0, 1'b0, 1'b0);
    chk_rd(tag, 1'b0, 8'h00);
  endtask

  initial begin
    //            wr    wd     rd    fl    cnt ovf   udf   rv    rdat
    vecs[0]  = '{1'b1, 8'h5C, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'h1F};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 8'h5C};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h5C};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h5C};
    vecs[4]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h5C};
    vecs[5]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'hA1};
    vecs[6]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'hA1};
    vecs[7]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'hA1};
    vecs[8]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'hA1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'hA1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'hA1};

    // Reset state while held in reset.
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Write 0x11..0x1F, then read them all back.
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
      chk_stat($sformatf("fill15[%0d]", i), i + 1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk_rd($sformatf("drain15[%0d]", i), 1'b1, 8'(8'h11 + i));
      chk_stat($sformatf("drain15[%0d]", i), 14 - i, 1'b0, 1'b0);
    end

    // Vector table: simultaneous op on empty, sticky underflow, flush priority.
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].fl);
      chk_stat($sformatf("vec[%0d]", i), vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
      chk_rd($sformatf("vec[%0d]", i), vecs[i].rv, vecs[i].rdat);
    end

    // Fill to 16, rejected writes at full, read-while-full, drain.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    chk_stat("full16", 16, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk_stat("ovf_wr", 16, 1'b1, 1'b0);
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    chk_stat("full_rdwr", 15, 1'b1, 1'b0);
    chk_rd("full_rdwr", 1'b1, 8'h20);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk_rd($sformatf("drain16[%0d]", i), 1'b1, 8'(8'h20 + i));
    end
    chk_stat("drained16", 0, 1'b1, 1'b0);

    // Steady state at count 8 with simultaneous traffic; pointers wrap.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      q.push_back(8'(8'h40 + i));
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
      chk_rd($sformatf("wrap[%0d]", i), 1'b1, q.pop_front());
      q.push_back(8'(8'h60 + i));
      chk($sformatf("wrap[%0d].count", i), 32'(count), 32'd8);
    end

    // Flush at full together with a write.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAB, 1'b0, 1'b0);
    chk_stat("pre_flush", 16, 1'b1, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk_stat("flush_wr", 0, 1'b0, 1'b0);
    chk_rd("flush_wr", 1'b0, last_rd);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_stat("post_flush_rd", 0, 1'b0, 1'b1);
    chk_rd("post_flush_rd", 1'b0, last_rd);

    // Asynchronous reset in the middle of a write burst.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    wr_en = 1'b1; wr_data = 8'hC4;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk_reset_vals("rst_held");
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk_reset_vals("rst_released");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_sync_fifo.md
# uart_sync_fifo

Parametrised single-clock FIFO that replaces the fixed 8×8 TX buffer between the APB register block and the UART transmitter, and is reused unchanged on the RX path. Independent read and write ports operate in the same cycle. The block adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.

## Interface
- DATA_W, 8: data word width in bits.
- DEPTH, 16: number of entries; power of two, ≥ 2.
- AF_LVL, DEPTH-2: almost_full asserts when count ≥ AF_LVL.
- AE_LVL, 2: almost_empty asserts when count ≤ AE_LVL.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (assert = 0).
- flush  in  1  synchronous clear of contents and error flags.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  rd_data updated this cycle (one-cycle pulse).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LVL.
- almost_empty  out  1  count ≤ AE_LVL.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a write was rejected because the FIFO was full.
- underflow  out  1  sticky: a read was rejected because the FIFO was empty.

## Operation
- Pointers are $clog2(DEPTH)+1 bits wide; the low bits address storage and the MSB is the wrap bit. full = MSBs differ and low bits equal. empty = pointers equal. Pointers wrap naturally modulo 2·DEPTH.
- count is a registered up/down counter: +1 on an accepted write only, −1 on an accepted read only, unchanged when both are accepted or neither is.
- Write is accepted iff wr_en && !full, evaluated on pre-edge state. A rejected write sets overflow and leaves storage and pointers untouched.
- Read is accepted iff rd_en && !empty, evaluated on pre-edge state. An accepted read loads rd_data with the head entry and pulses rd_valid. A rejected read sets underflow; rd_data holds its value and rd_valid = 0.
- Simultaneous write and read:
  - Not empty and not full: both accepted; count unchanged.
  - Empty: the write is accepted, the read is rejected and underflow is set. No write-through.
  - Full: the read is accepted, the write is rejected and overflow is set. No pass-through.
- flush has priority over wr_en and rd_en in the same cycle. It clears pointers, count, overflow and underflow, and drops any pending write or read. rd_data holds its value; rd_valid = 0.
- The sticky flags clear only on reset or flush.
- Storage is not reset; its contents are undefined until written.

## Timing
- Reset (rst = 0, asynchronous): rd_data = 0, rd_valid = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0. Pointers = 0. Release of reset is synchronous to clk.
- Read latency is 1 cycle: rd_en accepted at edge N produces rd_data/rd_valid valid after edge N.
- Write-to-read latency is 1 cycle: data written at edge N is readable (empty = 0) after edge N, so a read at edge N+1 returns it.
- All status outputs (full, empty, almost_*, count) derive from registered state. They reflect all accepted operations one edge after those operations.
- Reset asserted mid-burst: all state is cleared immediately without waiting for a clock edge. Data in flight is discarded.

## Structure
- Shared package uart_pkg holds:
  - UART_DATA_W = 8 and UART_FIFO_DEPTH = 16 defaults;
  - a status struct type fifo_status_t {full, empty, almost_full, almost_empty, overflow, underflow} for the APB status register.
- One sub-module, uart_fifo_ram: a DEPTH×DATA_W array with a registered write port and a combinational read port indexed by the read pointer.
- Pointer, count and flag logic stay in the top module.

## Test plan
- Reset, then write 0x11…0x1F (15 words) with DEPTH = 16 → count = 15, almost_full = 1 (AF_LVL = 14), full = 0. Read back all 15 → data in order, empty = 1 after the final read edge.
- Fill to 16, then assert wr_en with 0xAA → full = 1, overflow = 1, count = 16. Subsequent reads return the original data; 0xAA is never read.
- From empty, assert rd_en and wr_en with 0x5C together → underflow = 1, count = 1, rd_valid = 0. The next read returns 0x5C.
- Hold count at 8 and drive continuous simultaneous reads/writes for 40 cycles (pointers wrap more than twice) → count stays 8, and output order matches a scoreboard.
- At full, assert flush together with wr_en → count = 0, empty = 1, overflow = 0 on the next cycle, and no write occurs. Then pull rst low mid-write burst → all outputs return to reset values with no clock edge.
